div_result_bcd: RTL and testbench

//   Downstream stage of the 16-bit serial divider. Captures quotient and remainder when the

---
 rtl/div_result_bcd_pkg.sv | 13 +
 rtl/div_result_bcd_if.sv | 13 +
 rtl/div_result_bcd_step.sv | 19 +
 rtl/div_result_bcd.sv | 68 ++++++
 tb/tb_div_result_bcd.sv | 117 +++++++++++
 5 files changed

// File: rtl/div_result_bcd_pkg.sv
// div_fmt_pkg: shared types, sizes and the per-digit BCD correction for the divider result formatter
package div_fmt_pkg;
  typedef enum logic {IDLE, SHIFT} fmt_state_t;
  localparam int DIV_W = 16;
  localparam int BCD_DIGITS = 5;
  localparam int ACC_W = 4 * BCD_DIGITS;
  function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    for (int i = 0; i < BCD_DIGITS; i++)
      r[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/div_result_bcd_if.sv
// div_result_bcd_if: divider result in, packed BCD and status out
interface div_result_bcd_if #(parameter int WIDTH = 16, parameter int DIGITS = 5);
  logic                  div_ready;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  busy;
  logic                  done;
  logic                  overrun;
  modport master (output div_ready, quotient, remainder, input q_bcd, r_bcd, busy, done, overrun);
  modport slave  (input div_ready, quotient, remainder, output q_bcd, r_bcd, busy, done, overrun);
endinterface

// File: rtl/div_result_bcd_step.sv
// bin2bcd_step: one combinational double-dabble step (add-3 correction, then shift left by one)
module bin2bcd_step
  import div_fmt_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic [4*DIGITS-1:0] acc,
  input  logic [WIDTH-1:0]    sh,
  output logic [4*DIGITS-1:0] acc_next,
  output logic [WIDTH-1:0]    sh_next
);
  logic [ACC_W-1:0] fix;
  logic [4*DIGITS+WIDTH-1:0] cat;
  assign fix = add3_digits(ACC_W'(acc));
  assign cat = {fix[4*DIGITS-1:0], sh} << 1;
  assign acc_next = cat[4*DIGITS+WIDTH-1:WIDTH];
  assign sh_next = cat[WIDTH-1:0];
endmodule

// File: rtl/div_result_bcd.sv
// div_result_bcd: captures divider quotient/remainder on ready rise and converts both to packed BCD
module div_result_bcd
  import div_fmt_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input logic             Clk,
  input logic             Reset,
  div_result_bcd_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  fmt_state_t state;
  logic [CW-1:0] count;
  logic ready_d;
  logic [WIDTH-1:0] q_sh, r_sh, q_sh_n, r_sh_n;
  logic [4*DIGITS-1:0] q_acc, r_acc, q_acc_n, r_acc_n;
  logic capture;
  assign capture = bus.div_ready && !ready_d;
  bin2bcd_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q (.acc(q_acc), .sh(q_sh), .acc_next(q_acc_n), .sh_next(q_sh_n));
  bin2bcd_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r (.acc(r_acc), .sh(r_sh), .acc_next(r_acc_n), .sh_next(r_sh_n));
  // FSM: capture on ready rise, one dabble step per clock, publish both results together
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      ready_d <= 1'b1;
      q_sh <= '0;
      r_sh <= '0;
      q_acc <= '0;
      r_acc <= '0;
      bus.q_bcd <= '0;
      bus.r_bcd <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      ready_d <= bus.div_ready;
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (capture) begin
          q_sh <= bus.quotient;
          r_sh <= bus.remainder;
          q_acc <= '0;
          r_acc <= '0;
          count <= CW'(WIDTH);
          state <= SHIFT;
          bus.busy <= 1'b1;
          bus.overrun <= 1'b0;
        end
      end else begin
        q_sh <= q_sh_n;
        r_sh <= r_sh_n;
        q_acc <= q_acc_n;
        r_acc <= r_acc_n;
        count <= count - 1'b1;
        if (capture) bus.overrun <= 1'b1;
        if (count == CW'(1)) begin
          bus.q_bcd <= q_acc_n;
          bus.r_bcd <= r_acc_n;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: directed checks of capture, conversion, latency, overrun and reset abort
module tb_div_result_bcd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  div_result_bcd_if bus ();
  div_result_bcd dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic capture(input logic [15:0] q, input logic [15:0] r);
    bus.quotient = q;
    bus.remainder = r;
    bus.div_ready = 1'b0;
    tick();
    bus.div_ready = 1'b1;
    tick();
  endtask
  task automatic convert(input string tag, input logic [15:0] q, input logic [15:0] r,
                         input logic [19:0] qe, input logic [19:0] re);
    int cyc;
    capture(q, r);
    check({tag, " busy_after_capture"}, 32'(bus.busy), 32'd1);
    check({tag, " overrun_cleared"}, 32'(bus.overrun), 32'd0);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.done && cyc < 40);
    check({tag, " latency"}, 32'(cyc), 32'd16);
    check({tag, " q_bcd"}, 32'(bus.q_bcd), 32'(qe));
    check({tag, " r_bcd"}, 32'(bus.r_bcd), 32'(re));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    tick();
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask
  initial begin
    int dones;
    bus.div_ready = 1'b1;
    bus.quotient = '0;
    bus.remainder = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset q_bcd", 32'(bus.q_bcd), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset overrun", 32'(bus.overrun), 32'd0);
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    check("idle no activity", 32'(dones), 32'd0);
    check("idle r_bcd", 32'(bus.r_bcd), 32'd0);
    convert("t2", 16'd123, 16'd4, 20'h00123, 20'h00004);
    convert("t3a", 16'hFFFF, 16'h0000, 20'h65535, 20'h00000);
    convert("t3b", 16'd0, 16'd9999, 20'h00000, 20'h09999);
    capture(16'd42, 16'd7);
    bus.div_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bus.quotient = 16'd500;
    bus.remainder = 16'd6;
    bus.div_ready = 1'b1;
    tick();
    check("t4 overrun_set", 32'(bus.overrun), 32'd1);
    check("t4 still_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    check("t4 first_done", 32'(bus.done), 32'd1);
    check("t4 first_q", 32'(bus.q_bcd), 32'h00042);
    check("t4 first_r", 32'(bus.r_bcd), 32'h00007);
    check("t4 overrun_sticky", 32'(bus.overrun), 32'd1);
    convert("t4b", 16'd500, 16'd6, 20'h00500, 20'h00006);
    capture(16'd777, 16'd88);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    check("t5 reset_busy", 32'(bus.busy), 32'd0);
    check("t5 reset_q", 32'(bus.q_bcd), 32'd0);
    check("t5 reset_r", 32'(bus.r_bcd), 32'd0);
    check("t5 reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check("t5 no_done_after_abort", 32'(dones), 32'd0);
    convert("t5b", 16'd777, 16'd88, 20'h00777, 20'h00088);
    capture(16'd31415, 16'd2718);
    for (int i = 1; i <= 16; i++) begin
      bus.quotient = 16'($urandom);
      bus.remainder = 16'($urandom);
      if (i == 15) bus.div_ready = 1'b0;
      if (i == 16) bus.div_ready = 1'b1;
      tick();
    end
    check("t6 done", 32'(bus.done), 32'd1);
    check("t6 q_sampled", 32'(bus.q_bcd), 32'h31415);
    check("t6 r_sampled", 32'(bus.r_bcd), 32'h02718);
    check("t6 overrun_last_edge", 32'(bus.overrun), 32'd1);
    tick();
    check("t6 done_cleared", 32'(bus.done), 32'd0);
    check("t6 idle", 32'(bus.busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
